// File: rtl/risc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : risc_pkg
// Purpose  : Shared definitions for the six-stage 16-bit RISC pipeline
//            controller: opcode and ALU function codes, the per-stage control
//            word carried from DEC through WB, and the bubble constant.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package risc_pkg;

  // IR[15:12] opcodes
  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_SLT  = 4'h6;
  localparam logic [3:0] OP_ADDI = 4'h7;
  localparam logic [3:0] OP_LD   = 4'h8;
  localparam logic [3:0] OP_ST   = 4'h9;
  localparam logic [3:0] OP_BZ   = 4'hA;
  localparam logic [3:0] OP_JMP  = 4'hB;
  localparam logic [3:0] OP_BANK = 4'hC;

  // ALU function codes
  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_XOR = 4'd4;
  localparam logic [3:0] ALU_SLT = 4'd5;

  // Control word carried by each of the DEC/EXE/MEM/WB control registers
  typedef struct packed {
    logic       valid;
    logic       reg_write;
    logic       mem_to_reg;
    logic       mem_write;
    logic       alu_src;
    logic [3:0] alu_op;
    logic       sets_flag;
    logic       uses_rs1;
    logic       uses_rs2;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

endpackage
`default_nettype wire

// File: rtl/hazard_unit.sv
`default_nettype none
// ============================================================================
// Module   : hazard_unit
// Purpose  : Combinational operand-forwarding selects, load-use stall and
//            flag-hazard stall for the pipeline controller.
// Ports    : rr1/rr2        - DEC-stage source registers
//            wr_exe/wr_mem  - destination registers held in EXE and MEM
//            dec_*/exe_*/mem_* - control bits of the instructions in flight
//            ir_is_bz       - IR holds a BZ opcode
//            ir_live        - IR instruction is not being squashed
//            dr1_src/dr2_src- forwarding selects (0 MEM, 1 EXE, 2 RF, 3 load)
//            stall_lu       - register hazard that must hold DEC
//            stall_flag     - BZ waiting on an in-flight flag setter
// Config   : FORWARD_EN - when defined, EXE/MEM results are forwarded; when
//            undefined, selects stay on the register file and every RAW
//            hazard against EXE or MEM stalls like a load-use.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_unit #(
  parameter int RBITS = 4
) (
  input  logic [RBITS-1:0] rr1,
  input  logic [RBITS-1:0] rr2,
  input  logic [RBITS-1:0] wr_exe,
  input  logic [RBITS-1:0] wr_mem,
  input  logic             dec_valid,
  input  logic             dec_uses_rs1,
  input  logic             dec_uses_rs2,
  input  logic             dec_sets_flag,
  input  logic             exe_valid,
  input  logic             exe_reg_write,
  input  logic             exe_is_load,
  input  logic             exe_sets_flag,
  input  logic             mem_valid,
  input  logic             mem_reg_write,
  input  logic             mem_is_load,
  input  logic             ir_is_bz,
  input  logic             ir_live,
  output logic [1:0]       dr1_src,
  output logic [1:0]       dr2_src,
  output logic             stall_lu,
  output logic             stall_flag
);

`ifdef FORWARD_EN
  // First match wins: an ALU result in EXE is the youngest producer.
  function automatic logic [1:0] fwd_sel(input logic [RBITS-1:0] r);
    if (exe_valid && exe_reg_write && !exe_is_load && wr_exe == r) return 2'd1;
    if (mem_valid && mem_is_load && wr_mem == r)                   return 2'd3;
    if (mem_valid && mem_reg_write && wr_mem == r)                 return 2'd0;
    return 2'd2;
  endfunction

  assign dr1_src  = fwd_sel(rr1);
  assign dr2_src  = fwd_sel(rr2);
  // Load data is only available from MEM onward, so a consumer right
  // behind a load must wait one cycle.
  assign stall_lu = dec_valid && exe_valid && exe_is_load &&
                    ((dec_uses_rs1 && rr1 == wr_exe) ||
                     (dec_uses_rs2 && rr2 == wr_exe));
`else
  function automatic logic pending(input logic [RBITS-1:0] r);
    return (exe_valid && exe_reg_write && wr_exe == r) ||
           (mem_valid && mem_reg_write && wr_mem == r);
  endfunction

  logic unused_fwd;
  assign unused_fwd = exe_is_load ^ mem_is_load;

  assign dr1_src  = 2'd2;
  assign dr2_src  = 2'd2;
  assign stall_lu = dec_valid &&
                    ((dec_uses_rs1 && pending(rr1)) ||
                     (dec_uses_rs2 && pending(rr2)));
`endif

  // A squashed BZ never needs the flag, so it must not stall.
  assign stall_flag = ir_live && ir_is_bz &&
                      ((dec_valid && dec_sets_flag) ||
                       (exe_valid && exe_sets_flag));

endmodule
`default_nettype wire

// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_ctrl
// Purpose  : Pipeline control unit for the six-stage 16-bit RISC core.
//            Decodes the IR-stage opcode, carries control words through the
//            DEC/EXE/MEM/WB control registers, and generates forwarding
//            selects, stalls and jump/branch redirects with squash.
// Ports    : opcode                 - IR[15:12]
//            alu_z                  - EXE-stage ALU zero
//            rr1/rr2, wr_exe/wr_mem - register specifiers for hazard checks
//            pc_src..wr_src         - IR-stage combinational controls
//            stall_ld               - PC/IR/DEC enable (0 = hold)
//            stall_jmp/stall_dummy  - tied high
//            dr1_src/dr2_src        - DEC operand selects
//            alu_src/alu_op         - EXE controls
//            mem_we                 - MEM store enable
//            rfile_we/wd_src        - WB write enable and data select
// Config   : FORWARD_EN (see hazard_unit) selects forwarding vs. stalling.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_ctrl
  import risc_pkg::*;
#(
  parameter int RBITS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       opcode,
  input  logic             alu_z,
  input  logic [RBITS-1:0] rr1,
  input  logic [RBITS-1:0] rr2,
  input  logic [RBITS-1:0] wr_exe,
  input  logic [RBITS-1:0] wr_mem,
  output logic             pc_src,
  output logic             format_sel,
  output logic             bank_en,
  output logic             rr1_src,
  output logic             rr2_src,
  output logic             wr_src,
  output logic             stall_ld,
  output logic             stall_jmp,
  output logic             stall_dummy,
  output logic [1:0]       dr1_src,
  output logic [1:0]       dr2_src,
  output logic             alu_src,
  output logic [3:0]       alu_op,
  output logic             mem_we,
  output logic             rfile_we,
  output logic             wd_src
);

  ctrl_t r_dec, r_exe, r_mem, r_wb;
  ctrl_t w_ir_ctrl;
  logic  r_squash, r_zflag;
  logic  w_rtype, w_fire, w_redirect, w_stall_lu, w_stall_flag;

  function automatic ctrl_t alu_rr(input logic [3:0] fn);
    ctrl_t c;
    c           = CTRL_BUBBLE;
    c.valid     = 1'b1;
    c.reg_write = 1'b1;
    c.alu_op    = fn;
    c.sets_flag = 1'b1;
    c.uses_rs1  = 1'b1;
    c.uses_rs2  = 1'b1;
    return c;
  endfunction

  // IR-stage decode
  always_comb begin
    w_ir_ctrl       = CTRL_BUBBLE;
    w_ir_ctrl.valid = 1'b1;
    case (opcode)
      OP_ADD: w_ir_ctrl = alu_rr(ALU_ADD);
      OP_SUB: w_ir_ctrl = alu_rr(ALU_SUB);
      OP_AND: w_ir_ctrl = alu_rr(ALU_AND);
      OP_OR:  w_ir_ctrl = alu_rr(ALU_OR);
      OP_XOR: w_ir_ctrl = alu_rr(ALU_XOR);
      OP_SLT: w_ir_ctrl = alu_rr(ALU_SLT);
      OP_ADDI: begin
        w_ir_ctrl.reg_write = 1'b1;
        w_ir_ctrl.alu_src   = 1'b1;
        w_ir_ctrl.sets_flag = 1'b1;
        w_ir_ctrl.uses_rs1  = 1'b1;
      end
      OP_LD: begin
        w_ir_ctrl.reg_write  = 1'b1;
        w_ir_ctrl.mem_to_reg = 1'b1;
        w_ir_ctrl.alu_src    = 1'b1;
        w_ir_ctrl.uses_rs1   = 1'b1;
      end
      OP_ST: begin
        w_ir_ctrl.mem_write = 1'b1;
        w_ir_ctrl.alu_src   = 1'b1;
        w_ir_ctrl.uses_rs1  = 1'b1;
        w_ir_ctrl.uses_rs2  = 1'b1;
      end
      default: ;
    endcase
  end

  hazard_unit #(.RBITS(RBITS)) u_hazard (
    .rr1           (rr1),
    .rr2           (rr2),
    .wr_exe        (wr_exe),
    .wr_mem        (wr_mem),
    .dec_valid     (r_dec.valid),
    .dec_uses_rs1  (r_dec.uses_rs1),
    .dec_uses_rs2  (r_dec.uses_rs2),
    .dec_sets_flag (r_dec.sets_flag),
    .exe_valid     (r_exe.valid),
    .exe_reg_write (r_exe.reg_write),
    .exe_is_load   (r_exe.mem_to_reg),
    .exe_sets_flag (r_exe.sets_flag),
    .mem_valid     (r_mem.valid),
    .mem_reg_write (r_mem.reg_write),
    .mem_is_load   (r_mem.mem_to_reg),
    .ir_is_bz      (opcode == OP_BZ),
    .ir_live       (~r_squash),
    .dr1_src       (dr1_src),
    .dr2_src       (dr2_src),
    .stall_lu      (w_stall_lu),
    .stall_flag    (w_stall_flag)
  );

  assign w_rtype     = (opcode >= OP_ADD) && (opcode <= OP_SLT);
  assign stall_ld    = ~(w_stall_lu | w_stall_flag);
  assign w_fire      = stall_ld & ~r_squash;
  assign w_redirect  = w_fire & ((opcode == OP_JMP) | ((opcode == OP_BZ) & r_zflag));

  assign pc_src      = w_redirect;
  assign format_sel  = (opcode == OP_JMP);
  assign bank_en     = w_fire & (opcode == OP_BANK);
  assign rr1_src     = w_rtype;
  assign rr2_src     = w_rtype;
  assign wr_src      = ~w_rtype;
  assign stall_jmp   = 1'b1;
  assign stall_dummy = 1'b1;

  assign alu_src     = r_exe.alu_src;
  assign alu_op      = r_exe.alu_op;
  assign mem_we      = r_mem.valid & r_mem.mem_write;
  assign rfile_we    = r_wb.valid & r_wb.reg_write;
  assign wd_src      = r_wb.mem_to_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dec    <= CTRL_BUBBLE;
      r_exe    <= CTRL_BUBBLE;
      r_mem    <= CTRL_BUBBLE;
      r_wb     <= CTRL_BUBBLE;
      r_squash <= 1'b0;
      r_zflag  <= 1'b0;
    end else begin
      r_wb     <= r_mem;
      r_mem    <= r_exe;
      r_squash <= w_redirect;
      if (r_exe.valid && r_exe.sets_flag)
        r_zflag <= alu_z;
      if (w_stall_lu) begin
        // DEC holds its instruction; a bubble goes down the pipe.
        r_exe <= CTRL_BUBBLE;
      end else if (w_stall_flag) begin
        // Let the flag setter drain while BZ waits in IR.
        r_exe <= r_dec;
        r_dec <= CTRL_BUBBLE;
      end else begin
        r_exe <= r_dec;
        // Redirecting instructions have no downstream work.
        r_dec <= (w_fire && !w_redirect) ? w_ir_ctrl : CTRL_BUBBLE;
      end
    end
  end

  // WB only needs the write-related fields.
  logic unused_wb;
  assign unused_wb = ^{r_wb.mem_write, r_wb.alu_src, r_wb.alu_op,
                       r_wb.sets_flag, r_wb.uses_rs1, r_wb.uses_rs2};

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_ctrl
// Purpose  : Self-checking bench for pipe_ctrl. A reference model tracks the
//            opcode occupying each of DEC/EXE/MEM/WB and derives every output
//            from the instruction-level rules. Directed scenarios are followed
//            by randomized traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_ctrl;

  localparam int RBITS = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [3:0]       opcode = 4'h0;
  logic             alu_z = 1'b0;
  logic [RBITS-1:0] rr1 = '0, rr2 = '0, wr_exe = '0, wr_mem = '0;
  logic             pc_src, format_sel, bank_en, rr1_src, rr2_src, wr_src;
  logic             stall_ld, stall_jmp, stall_dummy;
  logic [1:0]       dr1_src, dr2_src;
  logic             alu_src;
  logic [3:0]       alu_op;
  logic             mem_we, rfile_we, wd_src;

  pipe_ctrl #(.RBITS(RBITS)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .alu_z(alu_z),
    .rr1(rr1), .rr2(rr2), .wr_exe(wr_exe), .wr_mem(wr_mem),
    .pc_src(pc_src), .format_sel(format_sel), .bank_en(bank_en),
    .rr1_src(rr1_src), .rr2_src(rr2_src), .wr_src(wr_src),
    .stall_ld(stall_ld), .stall_jmp(stall_jmp), .stall_dummy(stall_dummy),
    .dr1_src(dr1_src), .dr2_src(dr2_src), .alu_src(alu_src), .alu_op(alu_op),
    .mem_we(mem_we), .rfile_we(rfile_we), .wd_src(wd_src)
  );

  always #5 clk = ~clk;

  int ntests = 0;
  int nfail  = 0;

  // Model: opcode per stage (0 DEC, 1 EXE, 2 MEM, 3 WB), -1 = empty slot
  int m_op[4] = '{-1, -1, -1, -1};
  bit m_sq = 1'b0, m_z = 1'b0, m_known = 1'b0;

  function automatic bit writes(input int op);  return op >= 1 && op <= 8; endfunction
  function automatic bit is_ld(input int op);   return op == 8; endfunction
  function automatic bit flag_op(input int op); return op >= 1 && op <= 7; endfunction
  function automatic bit rd1(input int op);     return op >= 1 && op <= 9; endfunction
  function automatic bit rd2(input int op);     return (op >= 1 && op <= 6) || op == 9; endfunction
  function automatic int alu_of(input int op);  return (op >= 1 && op <= 6) ? op - 1 : 0; endfunction
  function automatic bit imm_of(input int op);  return op >= 7 && op <= 9; endfunction

  function automatic int fwd(input int r, input int we, input int wm);
    if (writes(m_op[1]) && !is_ld(m_op[1]) && we == r) return 1;
    if (is_ld(m_op[2]) && wm == r)                     return 3;
    if (writes(m_op[2]) && wm == r)                    return 0;
    return 2;
  endfunction

  function automatic bit busy(input int r, input int we, input int wm);
    return (writes(m_op[1]) && we == r) || (writes(m_op[2]) && wm == r);
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs on the falling edge, check, then advance model.
  task automatic step(input int op, input bit z, input int a, input int b,
                      input int we, input int wm, input bit r);
    int  e1, e2;
    bit  lu, fl, stl, fire, taken, rtype;
    @(negedge clk);
    opcode = op[3:0]; alu_z = z; rr1 = a[3:0]; rr2 = b[3:0];
    wr_exe = we[3:0]; wr_mem = wm[3:0]; rst = r;
    #1;
`ifdef FORWARD_EN
    e1 = fwd(a, we, wm);
    e2 = fwd(b, we, wm);
    lu = m_op[0] >= 0 && is_ld(m_op[1]) &&
         ((rd1(m_op[0]) && a == we) || (rd2(m_op[0]) && b == we));
`else
    e1 = 2;
    e2 = 2;
    lu = m_op[0] >= 0 && ((rd1(m_op[0]) && busy(a, we, wm)) ||
                          (rd2(m_op[0]) && busy(b, we, wm)));
`endif
    fl    = !m_sq && op == 10 && (flag_op(m_op[0]) || flag_op(m_op[1]));
    stl   = lu || fl;
    fire  = !stl && !m_sq;
    taken = fire && (op == 11 || (op == 10 && m_z));
    rtype = op >= 1 && op <= 6;
    if (m_known) begin
      chk("stall_ld",    stall_ld,    !stl);
      chk("pc_src",      pc_src,      taken);
      chk("format_sel",  format_sel,  op == 11);
      chk("bank_en",     bank_en,     fire && op == 12);
      chk("rr1_src",     rr1_src,     rtype);
      chk("rr2_src",     rr2_src,     rtype);
      chk("wr_src",      wr_src,      !rtype);
      chk("stall_jmp",   stall_jmp,   1'b1);
      chk("stall_dummy", stall_dummy, 1'b1);
      chk("dr1_src",     dr1_src,     e1[7:0]);
      chk("dr2_src",     dr2_src,     e2[7:0]);
      chk("alu_src",     alu_src,     imm_of(m_op[1]));
      chk("alu_op",      alu_op,      8'(alu_of(m_op[1])));
      chk("mem_we",      mem_we,      m_op[2] == 9);
      chk("rfile_we",    rfile_we,    writes(m_op[3]));
      chk("wd_src",      wd_src,      is_ld(m_op[3]));
    end
    if (r) begin
      m_op    = '{-1, -1, -1, -1};
      m_sq    = 1'b0;
      m_z     = 1'b0;
      m_known = 1'b1;
    end else begin
      if (flag_op(m_op[1])) m_z = z;
      m_op[3] = m_op[2];
      m_op[2] = m_op[1];
      if (lu) begin
        m_op[1] = -1;
      end else if (fl) begin
        m_op[1] = m_op[0];
        m_op[0] = -1;
      end else begin
        m_op[1] = m_op[0];
        m_op[0] = (fire && !taken) ? op : -1;
      end
      m_sq = taken;
    end
  endtask

  // Baseline register specifiers are all distinct: no accidental hazards.
  task automatic s(input int op, input bit z);
    step(op, z, 14, 15, 12, 13, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < 5; i++) s(0, 1'b0);
  endtask

  int nbank;

  initial begin
    // Reset
    step(0, 1'b0, 14, 15, 12, 13, 1'b1);
    step(0, 1'b0, 14, 15, 12, 13, 1'b1);
    chk("reset_stall_ld", stall_ld, 1'b1);
    chk("reset_rfile_we", rfile_we, 1'b0);
    chk("reset_mem_we",   mem_we,   1'b0);
    chk("reset_dr1_src",  dr1_src,  2'd2);
    s(0, 1'b0);

    // ADD r3 ; SUB reading r3
    s(1, 1'b0);
    s(2, 1'b0);
    step(0, 1'b0, 3, 15, 3, 13, 1'b0);
`ifdef FORWARD_EN
    chk("fwd_exe_dr1", dr1_src,  2'd1);
    chk("fwd_exe_stl", stall_ld, 1'b1);
`endif
    step(0, 1'b0, 3, 15, 12, 3, 1'b0);
`ifdef FORWARD_EN
    chk("fwd_mem_dr1", dr1_src, 2'd0);
`endif
    drain();

    // LD r1 ; ADD reading r1
    s(8, 1'b0);
    s(1, 1'b0);
    step(0, 1'b0, 1, 15, 1, 13, 1'b0);
    chk("lu_stall", stall_ld, 1'b0);
    step(0, 1'b0, 1, 15, 12, 1, 1'b0);
`ifdef FORWARD_EN
    chk("lu_release", stall_ld, 1'b1);
    chk("lu_dr1_ld",  dr1_src,  2'd3);
`endif
    drain();

    // JMP, wrong-path ST is squashed
    s(11, 1'b0);
    chk("jmp_pc_src", pc_src,     1'b1);
    chk("jmp_format", format_sel, 1'b1);
    s(9, 1'b0);
    chk("jmp_sq_pc_src", pc_src,     1'b0);
    chk("jmp_sq_format", format_sel, 1'b0);
    for (int i = 0; i < 4; i++) begin
      s(0, 1'b0);
      chk("jmp_sq_mem_we",   mem_we,   1'b0);
      chk("jmp_sq_rfile_we", rfile_we, 1'b0);
    end
    drain();

    // SUB r2,r2 (Z=1) ; BZ
    s(2, 1'b1);
    s(10, 1'b1);
    chk("bz_stall1", stall_ld, 1'b0);
    s(10, 1'b1);
    chk("bz_stall2", stall_ld, 1'b0);
    s(10, 1'b1);
    chk("bz_fire",   stall_ld,   1'b1);
    chk("bz_taken",  pc_src,     1'b1);
    chk("bz_format", format_sel, 1'b0);
    drain();

    // BANK held under a load-use stall
    nbank = 0;
    s(8, 1'b0);
    s(1, 1'b0);
    step(12, 1'b0, 1, 15, 1, 13, 1'b0);
    chk("bank_held", bank_en, 1'b0);
    nbank += int'(bank_en);
    s(12, 1'b0);
    nbank += int'(bank_en);
    s(0, 1'b0);
    nbank += int'(bank_en);
    chk("bank_once", 8'(nbank), 8'd1);
    drain();

    // Reset during a load-use stall clears everything
    s(8, 1'b0);
    s(1, 1'b0);
    step(0, 1'b0, 1, 15, 1, 13, 1'b1);
    s(0, 1'b0);
    chk("rst_mid_stall", stall_ld, 1'b1);

    // Randomized traffic with small register space and occasional reset
    for (int i = 0; i < 1500; i++) begin
      step(int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
           int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
           int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
           $urandom_range(0, 79) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
`default_nettype wire
